// File: rtl/hs_master_tx_if.sv
// Byte valid/ready link between the transmit master and the receiving slave.
// The master drives data and valid; the slave drives ready.
interface hs_master_tx_if;
    logic [7:0] M_data;
    logic       M_valid;
    logic       M_ready;

    modport master (
        output M_data,
        output M_valid,
        input  M_ready
    );

    modport slave (
        input  M_data,
        input  M_valid,
        output M_ready
    );
endinterface

// File: rtl/hs_master_tx.sv
// Transmit master: producer bytes are buffered in a small circular FIFO.
// Bytes are replayed on a valid/ready link, one per cycle while ready is high.
module hs_master_tx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    hs_master_tx_if.master           m,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         tx_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e           state_q;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       data_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic full;
    logic empty;
    logic wr_en;
    logic xfer;
    logic pop;
    logic [7:0] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_en = in_valid && !full;
    assign xfer  = valid_q && m.M_ready;
    // Pop whenever the output register is free or being vacated this edge.
    assign pop   = !empty && (state_q == IDLE || xfer);

    assign in_ready   = !full;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign tx_count   = cnt_q;
    assign m.M_data   = data_q;
    assign m.M_valid  = valid_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (xfer) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        data_q  <= head;
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (!empty) begin
                            data_q <= head;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hs_master_tx.sv
// Scoreboard bench for hs_master_tx: accepted writes queue expected bytes,
// a negedge monitor pops them on every transfer and checks hold stability.
module tb_hs_master_tx;
    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fifo_level;
    logic [15:0] tx_count;

    logic [7:0]  in_data2;
    logic        in_valid2;
    logic        in_ready2;
    logic [1:0]  fifo_level2;
    logic [3:0]  tx_count2;

    hs_master_tx_if bus ();
    hs_master_tx_if bus2 ();

    hs_master_tx #(.DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .m          (bus),
        .fifo_level (fifo_level),
        .tx_count   (tx_count)
    );

    hs_master_tx #(.DEPTH(2), .CNT_W(4)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .m          (bus2),
        .fifo_level (fifo_level2),
        .tx_count   (tx_count2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_x2    = 0;
    logic [7:0] exp_q [$];
    logic       hold;
    logic [7:0] hold_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0;
            n_x2 = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(bus.M_valid), 32'd1);
                chk("hold_data", 32'(bus.M_data), 32'(hold_data));
            end
            if (bus.M_valid && bus.M_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(bus.M_data), 32'hFFFF_FFFF);
                end else begin
                    chk("order", 32'(bus.M_data), 32'(exp_q.pop_front()));
                end
            end
            hold      = bus.M_valid && !bus.M_ready;
            hold_data = bus.M_data;
            if (bus2.M_valid && bus2.M_ready) n_x2++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        in_valid2    = 1'b0;
        in_data2     = 8'h00;
        bus.M_ready  = 1'b0;
        bus2.M_ready = 1'b0;
        #3;
        exp_q.delete();
        chk("rst_valid", 32'(bus.M_valid), 32'd0);
        chk("rst_data", 32'(bus.M_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_count", 32'(tx_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic put(input logic [7:0] b);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (acc) exp_q.push_back(b);
        else chk("put_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int i;
        bus.M_ready = 1'b1;
        i = 0;
        while ((exp_q.size() != 0 || bus.M_valid) && i < 200) begin
            tick();
            i++;
        end
        if (i >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        #2;
        // 1: single byte latency
        do_reset();
        bus.M_ready = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'h11;
        tick();
        exp_q.push_back(8'h11);
        in_valid = 1'b0;
        chk("t1_valid_early", 32'(bus.M_valid), 32'd0);
        chk("t1_level", 32'(fifo_level), 32'd1);
        tick();
        chk("t1_valid", 32'(bus.M_valid), 32'd1);
        chk("t1_data", 32'(bus.M_data), 32'h11);
        tick();
        chk("t1_valid_drop", 32'(bus.M_valid), 32'd0);
        chk("t1_count", 32'(tx_count), 32'd1);
        chk("t1_data_kept", 32'(bus.M_data), 32'h11);

        // 2: back-to-back, no bubble
        do_reset();
        bus.M_ready = 1'b1;
        for (int k = 1; k <= 4; k++) put(8'(k));
        tick();
        tick();
        chk("t2_count", 32'(tx_count), 32'd4);
        chk("t2_valid", 32'(bus.M_valid), 32'd0);
        chk("t2_empty_q", 32'(exp_q.size()), 32'd0);

        // 3: stall, fill, refuse, release
        do_reset();
        for (int k = 0; k < 5; k++) put(8'h20 + 8'(k));
        chk("t3_valid", 32'(bus.M_valid), 32'd1);
        chk("t3_data", 32'(bus.M_data), 32'h20);
        chk("t3_level", 32'(fifo_level), 32'd4);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h25;
        tick();
        in_valid = 1'b0;
        chk("t3_refused", 32'(fifo_level), 32'd4);
        drain();
        chk("t3_count", 32'(tx_count), 32'd5);

        // 4: ready 1,1,1,0 with 32 continuous writes
        do_reset();
        begin
            int sent;
            int cyc;
            logic acc;
            sent = 0;
            cyc  = 0;
            while ((sent < 32 || exp_q.size() != 0 || bus.M_valid) && cyc < 300) begin
                bus.M_ready = (cyc % 4 != 3);
                in_valid    = (sent < 32);
                in_data     = 8'h40 + 8'(sent);
                acc         = in_valid && in_ready;
                tick();
                if (acc) begin
                    exp_q.push_back(in_data);
                    sent++;
                end
                cyc++;
            end
            in_valid = 1'b0;
            chk("t4_sent", 32'(sent), 32'd32);
            chk("t4_count", 32'(tx_count), 32'd32);
            chk("t4_empty_q", 32'(exp_q.size()), 32'd0);
        end

        // 5: full with simultaneous pop
        do_reset();
        for (int k = 0; k < 5; k++) put(8'h30 + 8'(k));
        chk("t5_full", 32'(fifo_level), 32'd4);
        in_valid    = 1'b1;
        in_data     = 8'h35;
        bus.M_ready = 1'b1;
        tick();
        chk("t5_pop_only", 32'(fifo_level), 32'd3);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        bus.M_ready = 1'b0;
        tick();
        exp_q.push_back(8'h35);
        in_valid = 1'b0;
        chk("t5_refill", 32'(fifo_level), 32'd4);
        drain();
        chk("t5_count", 32'(tx_count), 32'd6);

        // 6: reset mid-stream
        do_reset();
        for (int k = 0; k < 4; k++) put(8'h50 + 8'(k));
        bus.M_ready = 1'b1;
        tick();
        bus.M_ready = 1'b0;
        chk("t6_pre_count", 32'(tx_count), 32'd1);
        chk("t6_pre_valid", 32'(bus.M_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.M_valid), 32'd0);
        chk("t6_async_count", 32'(tx_count), 32'd0);
        chk("t6_async_level", 32'(fifo_level), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst         = 1'b1;
        bus.M_ready = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'hA5;
        tick();
        exp_q.push_back(8'hA5);
        in_valid = 1'b0;
        chk("t6_valid_early", 32'(bus.M_valid), 32'd0);
        tick();
        chk("t6_valid", 32'(bus.M_valid), 32'd1);
        chk("t6_data", 32'(bus.M_data), 32'hA5);
        tick();
        chk("t6_count", 32'(tx_count), 32'd1);

        // 7: 4-bit counter wraps after 17 transfers
        do_reset();
        begin
            int sent;
            int cyc;
            logic acc;
            sent         = 0;
            cyc          = 0;
            bus2.M_ready = 1'b1;
            while ((sent < 17 || bus2.M_valid) && cyc < 200) begin
                in_valid2 = (sent < 17);
                in_data2  = 8'(sent);
                acc       = in_valid2 && in_ready2;
                tick();
                if (acc) sent++;
                cyc++;
            end
            in_valid2 = 1'b0;
            chk("t7_xfers", 32'(n_x2), 32'd17);
            chk("t7_wrap", 32'(tx_count2), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hs_master_tx.md
Name: hs_master_tx

Overview:
- Transmit end of the 8-bit valid/ready byte handshake; drives the `S_valid`/`S_data`/`S_ready` interface of the receiving slave.
- Accepts bytes from a local producer into a small FIFO and presents them one at a time on `M_valid`/`M_data`.
- Holds each byte stable until the receiver asserts `M_ready`.
- Sustains one byte per cycle while `M_ready` stays high; absorbs the receiver's periodic ready drops (ready low one cycle in four) without loss.

Parameters:
- `DEPTH`, 4, FIFO entries; power of two, 2..16.
- `CNT_W`, 16, width of `tx_count`.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  byte from local producer.
- `in_valid`  in  1  producer offers `in_data` this cycle.
- `in_ready`  out  1  FIFO can accept; write occurs when `in_valid && in_ready` at rising edge.
- `M_data`  out  8  byte to receiver (connects to `S_data`).
- `M_valid`  out  1  `M_data` holds a valid byte (connects to `S_valid`).
- `M_ready`  in  1  receiver accepts (connects to `S_ready`).
- `fifo_level`  out  clog2(DEPTH)+1  bytes stored in FIFO, excluding the output register.
- `tx_count`  out  CNT_W  bytes transferred since reset.

Behaviour:
- Reset (`rst`=0, async):
  - `M_valid`=0, `M_data`=0, `fifo_level`=0, `tx_count`=0, `in_ready`=1.
  - Pointers cleared; FIFO contents discarded.
- Transfer rule: a byte is transferred at a rising edge where `M_valid && M_ready`.
  - `M_valid` never depends combinationally on `M_ready`.
  - Once `M_valid`=1, `M_valid` and `M_data` hold unchanged until the transfer edge.
- FIFO:
  - Circular buffer with rd/wr pointers of clog2(DEPTH) bits plus a wrap bit.
  - Full when pointers are equal and wrap bits differ; empty when pointers and wrap bits are equal.
  - `in_ready` = not full, derived from registered state only.
- Output state machine, two states:
  - IDLE (`M_valid`=0): if FIFO non-empty, load output register from FIFO head, pop, go to SEND.
  - SEND (`M_valid`=1), transfer edge with FIFO non-empty: load next head, pop, stay in SEND (back-to-back; no bubble).
  - SEND, transfer edge with FIFO empty: go to IDLE, `M_valid`=0; `M_data` keeps its last value.
  - SEND, no transfer: hold.
- Latency: a byte written at edge N into an empty FIFO with IDLE output gives `M_valid`=1 with that byte from edge N+1.
- Ordering: strict FIFO order; no drop, no duplication.
- Simultaneous write and pop:
  - Both take effect; `fifo_level` unchanged.
  - When full, a write is refused even if a pop occurs on the same edge, because `in_ready` was 0.
  - A write while empty, with a pop on the same edge, is impossible: a pop requires non-empty.
- `fifo_level` updates on the edge: +1 write only, -1 pop only, unchanged for both or neither.
- `tx_count` increments by 1 on each transfer edge; wraps from 2^CNT_W-1 to 0.
- Reset mid-operation:
  - `M_valid` drops asynchronously.
  - Pending and in-flight bytes are lost.
  - After release, the first new write follows normal latency.
- Capacity: `DEPTH` bytes in FIFO plus 1 in the output register.

Test Plan:
1. Reset release, write 0x11 with `M_ready`=1 → `M_valid`=1, `M_data`=0x11 from the next edge; transfer one edge later; `tx_count`=1; `M_valid` returns to 0.
2. Write 0x01..0x04 back-to-back with `M_ready` held 1 → `M_data` sequence 0x01,0x02,0x03,0x04 on consecutive cycles, no bubble; `tx_count`=4.
3. `M_ready`=0, write 0x20..0x24 → output holds 0x20 with `M_valid`=1; `fifo_level`=4; `in_ready`=0; 6th write refused; release `M_ready` → 0x20..0x24 delivered in order.
4. `M_ready` pattern 1,1,1,0 repeating with 32 continuous writes → all 32 bytes received in order; `M_data` stable during every ready-low cycle; `tx_count`=32.
5. Full FIFO with simultaneous pop and `in_valid`=1 → write refused that edge, accepted the next; `fifo_level` returns to 4.
6. Assert `rst`=0 mid-stream with `M_valid`=1 → `M_valid`=0, `tx_count`=0, `fifo_level`=0 immediately; after release, new byte 0xA5 appears with single-cycle latency.
7. Preload `tx_count` near wrap (CNT_W=4 build), 17 transfers → count reads 1.
